// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the round-robin ALU arbiter and its ALU.
// The optional grant statistics are controlled by the ALU_ARB_STATS_EN macro.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_EQL = 3'b111;

    localparam int CNT_W = 16;

    // Width of a requester index; at least one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/Simple_ALU.sv
// 8-bit combinational ALU shared by the arbiter's requesters.
// Shifts use the low three bits of b; EQL returns 1 when a equals b, else 0.
module Simple_ALU
    import alu_arb_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [2:0] op_i,
    output logic [7:0] alu_o
);

    always_comb begin
        alu_o = '0;
        case (op_i)
            OP_ADD:  alu_o = a_i + b_i;
            OP_SUB:  alu_o = a_i - b_i;
            OP_SLL:  alu_o = a_i << b_i[2:0];
            OP_SRL:  alu_o = a_i >> b_i[2:0];
            OP_AND:  alu_o = a_i & b_i;
            OP_OR:   alu_o = a_i | b_i;
            OP_XOR:  alu_o = a_i ^ b_i;
            OP_EQL:  alu_o = {7'd0, (a_i == b_i)};
            default: alu_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester found searching
// upward from (last+1) mod NUM_REQ, wrapping; no grant when nothing requests.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one Simple_ALU between NUM_REQ valid/ready requesters, round-robin.
// Define ALU_ARB_STATS_EN to add per-requester saturating grant counters (gnt_cnt_o).
//
// Handshakes: a request transfers on a cycle where req_valid_i[k] & req_ready_o[k];
// a response transfers where rsp_valid_o[k] & rsp_ready_i[k]. Valid never depends
// on ready, and a presented request must hold a/b/op stable until it transfers.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3,
    parameter int NUM_REQ = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    input  logic [NUM_REQ*OP_W-1:0]   req_op_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    input  logic [NUM_REQ-1:0]        rsp_ready_i,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic                      busy_o
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0]  gnt_cnt_o
`endif
);

    localparam int IDX_W = idx_w(NUM_REQ);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   last_q, gnt_q, arb_idx;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [DATA_W-1:0]  a_q, b_q, alu_res, rsp_data_q;
    logic [OP_W-1:0]    op_q;
    logic               req_fire, rsp_fire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req_valid_i),
        .last    (last_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    Simple_ALU u_alu (
        .a_i   (a_q),
        .b_i   (b_q),
        .op_i  (op_q),
        .alu_o (alu_res)
    );

    // The arbiter only grants valid requesters, so any grant in IDLE is a transfer.
    assign req_fire = (state_q == IDLE) && (|arb_gnt);
    assign rsp_fire = (state_q == RESP) && rsp_ready_i[gnt_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_fire) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        busy_o      = 1'b1;
        case (state_q)
            IDLE: begin
                req_ready_o = arb_gnt;
                busy_o      = 1'b0;
            end
            RESP:    rsp_valid_o[gnt_q] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            gnt_q      <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
            rsp_data_q <= '0;
        end else begin
            if (req_fire) begin
                a_q   <= req_a_i[arb_idx*DATA_W +: DATA_W];
                b_q   <= req_b_i[arb_idx*DATA_W +: DATA_W];
                op_q  <= req_op_i[arb_idx*OP_W +: OP_W];
                gnt_q <= arb_idx;
            end
            if (state_q == EXEC) begin
                rsp_data_q <= alu_res;
            end
            if (rsp_fire) begin
                last_q <= gnt_q;
            end
        end
    end

    assign rsp_data_o = rsp_data_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cnt_q[k] <= '0;
            end
        end else if (req_fire && (cnt_q[arb_idx] != '1)) begin
            cnt_q[arb_idx] <= cnt_q[arb_idx] + 1'b1;
        end
    end

    always_comb begin
        gnt_cnt_o = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            gnt_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_alu_arbiter;

    localparam int N  = 2;
    localparam int DW = 8;
    localparam int OW = 3;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N*DW-1:0] req_a_i = '0;
    logic [N*DW-1:0] req_b_i = '0;
    logic [N*OW-1:0] req_op_i = '0;
    logic [N-1:0]    rsp_valid_o;
    logic [N-1:0]    rsp_ready_i = '1;
    logic [DW-1:0]   rsp_data_o;
    logic            busy_o;
`ifdef ALU_ARB_STATS_EN
    logic [N*16-1:0] gnt_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(DW), .OP_W(OW), .NUM_REQ(N)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_op_i    (req_op_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .busy_o      (busy_o)
`ifdef ALU_ARB_STATS_EN
        ,
        .gnt_cnt_o   (gnt_cnt_o)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        int r;
        case (op)
            3'd0: r = int'(a) + int'(b);
            3'd1: r = int'(a) - int'(b);
            3'd2: r = int'(a) * (1 << (b % 8));
            3'd3: r = int'(a) / (1 << (b % 8));
            3'd4: r = int'(a & b);
            3'd5: r = int'(a | b);
            3'd6: r = int'(a ^ b);
            default: r = (a == b) ? 1 : 0;
        endcase
        return 8'(r & 255);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    logic [DW-1:0] exp_q[$];
    int            last_m = N - 1;
    bit            busy_m = 1'b0;
    int            age_m  = 0;
    int            gnt_m  = 0;
    int            cnt_m[N];
    int            pick_m;
    logic [N-1:0]  acc_vec = '0;
    logic [N-1:0]  exp_ready, exp_rvalid;

    always @(negedge clk) begin : compare
        pick_m     = rr_pick(req_valid_i, last_m);
        exp_ready  = '0;
        exp_rvalid = '0;
        if (!busy_m && pick_m >= 0) exp_ready[pick_m] = 1'b1;
        if (busy_m && age_m >= 2) exp_rvalid[gnt_m] = 1'b1;
        if (chk_en) begin
            chk("model_req_ready", 32'(req_ready_o), 32'(exp_ready));
            chk("model_rsp_valid", 32'(rsp_valid_o), 32'(exp_rvalid));
            chk("model_busy", 32'(busy_o), 32'(busy_m));
            if (exp_rvalid != '0) chk("model_rsp_data", 32'(rsp_data_o), 32'(exp_q[0]));
`ifdef ALU_ARB_STATS_EN
            for (int k = 0; k < N; k++) chk("model_gnt_cnt", 32'(gnt_cnt_o[k*16 +: 16]), 32'(cnt_m[k]));
`endif
        end
        acc_vec = '0;
        if (rst_i) begin
            busy_m = 1'b0;
            last_m = N - 1;
            exp_q.delete();
            for (int k = 0; k < N; k++) cnt_m[k] = 0;
        end else if (!busy_m) begin
            if (pick_m >= 0) begin
                busy_m = 1'b1;
                age_m  = 1;
                gnt_m  = pick_m;
                acc_vec[pick_m] = 1'b1;
                exp_q.push_back(alu_ref(req_a_i[pick_m*DW +: DW], req_b_i[pick_m*DW +: DW],
                                        req_op_i[pick_m*OW +: OW]));
                if (cnt_m[pick_m] < 65535) cnt_m[pick_m]++;
            end
        end else if (age_m == 1) begin
            age_m = 2;
        end else if (rsp_ready_i[gnt_m]) begin
            last_m = gnt_m;
            busy_m = 1'b0;
            void'(exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        req_valid_i[k]        = 1'b1;
        req_a_i[k*DW +: DW]   = a;
        req_b_i[k*DW +: DW]   = b;
        req_op_i[k*OW +: OW]  = op;
    endtask

    int seen[$];

    initial begin
        for (int k = 0; k < N; k++) cnt_m[k] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_i  = 1'b0;
        chk_en = 1'b1;

        // reset state
        @(negedge clk);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_rsp_data", 32'(rsp_data_o), 32'd0);
        chk("reset_req_ready", 32'(req_ready_o), 32'd0);

        // single op: 1 << 7
        tick();
        drive_req(0, 8'h01, 8'h07, 3'b010);
        rsp_ready_i = 2'b01;
        @(negedge clk);
        chk("single_ready", 32'(req_ready_o), 32'h1);
        tick();
        req_valid_i = '0;
        @(negedge clk);
        chk("single_exec_rsp_valid", 32'(rsp_valid_o), 32'h0);
        tick();
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("single_rsp_data", 32'(rsp_data_o), 32'h80);
        tick();

        // simultaneous after reset
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        drive_req(0, 8'hAA, 8'hAA, 3'b111);
        drive_req(1, 8'h3C, 8'h0F, 3'b000);
        rsp_ready_i = 2'b11;
        @(negedge clk);
        chk("simul_first_grant", 32'(req_ready_o), 32'h1);
        tick();
        req_valid_i[0] = 1'b0;
        @(negedge clk);
        chk("simul_exec_ready", 32'(req_ready_o), 32'h0);
        tick();
        @(negedge clk);
        chk("simul_rsp0_valid", 32'(rsp_valid_o), 32'h1);
        chk("simul_rsp0_data", 32'(rsp_data_o), 32'h01);
        tick();
        @(negedge clk);
        chk("simul_second_grant", 32'(req_ready_o), 32'h2);
        tick();
        req_valid_i = '0;
        tick();
        @(negedge clk);
        chk("simul_rsp1_valid", 32'(rsp_valid_o), 32'h2);
        chk("simul_rsp1_data", 32'(rsp_data_o), 32'h4B);
        repeat (3) tick();

        // round-robin fairness over 6 operations
        drive_req(0, 8'h11, 8'h22, 3'b110);
        drive_req(1, 8'h40, 8'h02, 3'b011);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (req_ready_o != '0) begin
                seen.push_back(req_ready_o[1] ? 1 : 0);
                chk("fair_busy_in_idle", 32'(busy_o), 32'd0);
            end else begin
                chk("fair_busy_between", 32'(busy_o), 32'd1);
            end
            tick();
        end
        req_valid_i = '0;
        chk("fair_grant_count", 32'(seen.size()), 32'd6);
        for (int g = 0; g < 6 && g < seen.size(); g++) chk("fair_grant_seq", 32'(seen[g]), 32'(g % 2));
        repeat (2) tick();

        // response backpressure, with the other requester's ready toggling
        drive_req(0, 8'h05, 8'h03, 3'b001);
        rsp_ready_i = 2'b00;
        @(negedge clk);
        chk("bp_grant", 32'(req_ready_o), 32'h1);
        tick();
        req_valid_i = '0;
        tick();
        @(negedge clk);
        chk("bp_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("bp_rsp_data", 32'(rsp_data_o), 32'h02);
        for (int c = 0; c < 5; c++) begin
            tick();
            rsp_ready_i = (c % 2 == 0) ? 2'b10 : 2'b00;
            @(negedge clk);
            chk("bp_hold_valid", 32'(rsp_valid_o), 32'h1);
            chk("bp_hold_data", 32'(rsp_data_o), 32'h02);
            chk("bp_hold_ready", 32'(req_ready_o), 32'h0);
        end
        tick();
        rsp_ready_i = 2'b01;
        @(negedge clk);
        chk("bp_release_valid", 32'(rsp_valid_o), 32'h1);
        tick();
        @(negedge clk);
        chk("bp_done_valid", 32'(rsp_valid_o), 32'h0);
        chk("bp_done_busy", 32'(busy_o), 32'd0);

        // reset in the middle of an operation
        tick();
        rsp_ready_i = 2'b11;
        drive_req(0, 8'h09, 8'h09, 3'b100);
        drive_req(1, 8'h0F, 8'hF0, 3'b101);
        @(negedge clk);
        chk("rst_mid_grant", 32'(req_ready_o), 32'h2);
        tick();
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_mid_exec_busy", 32'(busy_o), 32'd1);
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("rst_mid_next_grant", 32'(req_ready_o), 32'h1);
        tick();
        req_valid_i = '0;
        repeat (4) tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req_valid_i[k] || acc_vec[k]) begin
                    req_valid_i[k]       = ($urandom_range(0, 2) != 0);
                    req_a_i[k*DW +: DW]  = 8'($urandom_range(0, 255));
                    req_b_i[k*DW +: DW]  = 8'($urandom_range(0, 255));
                    req_op_i[k*OW +: OW] = 3'($urandom_range(0, 7));
                end
                rsp_ready_i[k] = ($urandom_range(0, 9) < 7);
            end
            rst_i = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst_i       = 1'b0;
        req_valid_i = '0;
        rsp_ready_i = '1;
        repeat (6) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
